// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith ops and iterative
// multiply-low, unsigned divide and unsigned remainder. One op in flight.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ANDN  = 4'b0100;
  localparam logic [3:0] OP_ORN   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_MULLO = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_REMU  = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;     // multiplicand (MULLO) / dividend-then-quotient (DIV/REM)
  logic [WIDTH-1:0] b_q, b_d;     // multiplier (MULLO) / divisor (DIV/REM)
  logic [WIDTH-1:0] acc_q, acc_d; // product accumulator / partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cmp_q, cmp_d; // A==B captured at accept, published on completion
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  function automatic logic is_iter(input logic [3:0] o);
    return (o == OP_MULLO) || (o == OP_DIVU) || (o == OP_REMU);
  endfunction

  function automatic logic is_single(input logic [3:0] o);
    case (o)
      OP_AND, OP_OR, OP_ADD, OP_ANDN, OP_ORN, OP_SUB, OP_SLTU: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  // Illegal encodings fall through to zero.
  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] o,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z);
    case (o)
      OP_AND:  return x & z;
      OP_OR:   return x | z;
      OP_ADD:  return x + z;
      OP_ANDN: return x & ~z;
      OP_ORN:  return x | ~z;
      OP_SUB:  return x - z;
      OP_SLTU: return {{(WIDTH-1){1'b0}}, (x < z)};
      default: return '0;
    endcase
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign zero      = zero_q;
  assign err       = err_q;

  // Next-state, iteration step and result capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    y_d     = y_q;
    zero_d  = zero_q;
    err_d   = err_q;

    // One shift-add step.
    mul_acc = acc_q + (b_q[0] ? a_q : '0);
    // One restoring-divide step. With a zero divisor the compare always
    // succeeds, giving an all-ones quotient and the dividend as remainder.
    rem_sh  = {acc_q, a_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, b_q});
    rem_sub = rem_sh[WIDTH-1:0] - b_q;
    div_rem = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
    div_quo = {a_q[WIDTH-2:0], rem_ge};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          cmp_d = (a == b);
          if (is_iter(op)) begin
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            y_d     = alu_single(op, a, b);
            zero_d  = (a == b);
            err_d   = ~is_single(op);
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (op_q == OP_MULLO) begin
          acc_d = mul_acc;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = div_rem;
          a_d   = div_quo;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
          zero_d  = cmp_q;
          err_d   = 1'b0;
          if (op_q == OP_MULLO)     y_d = mul_acc;
          else if (op_q == OP_DIVU) y_d = div_quo;
          else                      y_d = div_rem;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cmp_q   <= 1'b0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

endmodule
